// File: rtl/traffic_phase_ctrl_if.sv
// Sensor/flash inputs and lamp/status outputs of traffic_phase_ctrl.
// master drives sensors and flash request; slave is the controller.
interface traffic_phase_ctrl_if #(
  parameter int NUM_PHASES = 4
);
  localparam int AW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  logic [NUM_PHASES-1:0]   S;
  logic                    Flash;
  logic [2*NUM_PHASES-1:0] Lights;
  logic [AW-1:0]           ActivePhase;
  logic                    FlashActive;

  modport master (
    output S, Flash,
    input  Lights, ActivePhase, FlashActive
  );

  modport slave (
    input  S, Flash,
    output Lights, ActivePhase, FlashActive
  );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// N-phase actuated signal controller: adaptive green, yellow, all-red,
// round-robin demand service and a flash mode. Outputs are registered.
module traffic_phase_ctrl #(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 8,
  parameter int MIN_GREEN  = 10,
  parameter int MAX_GREEN  = 45,
  parameter int EXT_GAP    = 3,
  parameter int YELLOW_DUR = 5,
  parameter int ALLRED_DUR = 2,
  parameter int FLASH_HALF = 4,
  parameter int REST_PHASE = 0
) (
  input  logic                Clock,
  input  logic                Reset,
  traffic_phase_ctrl_if.slave bus
);
  localparam int AW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  localparam logic [1:0] ST_GREEN  = 2'd0;
  localparam logic [1:0] ST_YELLOW = 2'd1;
  localparam logic [1:0] ST_ALLRED = 2'd2;
  localparam logic [1:0] ST_FLASH  = 2'd3;

  localparam logic [1:0] L_GRN  = 2'b01;
  localparam logic [1:0] L_YEL  = 2'b10;
  localparam logic [1:0] L_DARK = 2'b00;

  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_MIN  = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] C_GAP  = CNT_W'(EXT_GAP);
  localparam logic [CNT_W-1:0] C_YEL  = CNT_W'(YELLOW_DUR);
  localparam logic [CNT_W-1:0] C_AR   = CNT_W'(ALLRED_DUR);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(FLASH_HALF);
  localparam logic [AW-1:0]    C_REST = AW'(REST_PHASE);

  logic [1:0]              r_state, w_state_n;
  logic [CNT_W-1:0]        r_timer, w_timer_n;
  logic [CNT_W-1:0]        r_g, w_g_n;
  logic [CNT_W-1:0]        r_gap, w_gap_n;
  logic [CNT_W-1:0]        r_fcnt, w_fcnt_n;
  logic                    r_lit, w_lit_n;
  logic                    r_rest, w_rest_n;
  logic [NUM_PHASES-1:0]   r_dem, w_dem_n;
  logic [NUM_PHASES-1:0]   w_dem_eff, w_mask, w_own;
  logic [AW-1:0]           r_ap, w_ap_n, w_scan;
  logic                    w_other, w_t_done, w_g_done;
  logic [2*NUM_PHASES-1:0] r_lights, w_lights_n;
  logic                    r_flash_act;

  always_comb begin
    w_own       = '0;
    w_own[r_ap] = 1'b1;
  end

  // The green phase never latches its own sensor; flash latches nothing.
  always_comb begin
    case (r_state)
      ST_GREEN: w_mask = ~w_own;
      ST_FLASH: w_mask = '0;
      default:  w_mask = '1;
    endcase
  end

  assign w_dem_eff = r_dem | (bus.S & w_mask);
  assign w_other   = |(w_dem_eff & ~w_own);
  assign w_t_done  = (r_timer <= C_ONE);
  assign w_g_done  = (r_g >= C_MIN) &&
                     (bus.Flash ||
                      (w_other && (r_gap == '0 || r_g == C_MAX)));

  // Descending scan so the nearest requester after r_ap wins.
  always_comb begin
    int idx;
    idx    = 0;
    w_scan = C_REST;
    for (int k = NUM_PHASES; k >= 1; k--) begin
      idx = (int'(r_ap) + k) % NUM_PHASES;
      if (w_dem_eff[idx]) w_scan = AW'(idx);
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_timer_n = r_timer;
    w_g_n     = r_g;
    w_gap_n   = r_gap;
    w_fcnt_n  = r_fcnt;
    w_lit_n   = r_lit;
    w_rest_n  = r_rest;
    w_dem_n   = w_dem_eff;
    w_ap_n    = r_ap;
    case (r_state)
      ST_GREEN: begin
        w_g_n = (r_g == C_MAX) ? C_MAX : r_g + C_ONE;
        if (bus.S[r_ap])     w_gap_n = C_GAP;
        else if (r_gap != 0) w_gap_n = r_gap - C_ONE;
        if (w_g_done) begin
          w_state_n = ST_YELLOW;
          w_timer_n = C_YEL;
        end
      end
      ST_YELLOW: begin
        if (w_t_done) begin
          w_state_n = ST_ALLRED;
          w_timer_n = C_AR;
        end else begin
          w_timer_n = r_timer - C_ONE;
        end
      end
      ST_ALLRED: begin
        if (!w_t_done) begin
          w_timer_n = r_timer - C_ONE;
        end else if (bus.Flash) begin
          w_state_n = ST_FLASH;
          w_fcnt_n  = C_HALF;
          w_lit_n   = 1'b1;
          w_dem_n   = '0;
        end else begin
          w_state_n       = ST_GREEN;
          w_ap_n          = r_rest ? C_REST : w_scan;
          w_rest_n        = 1'b0;
          w_g_n           = C_ONE;
          w_gap_n         = C_GAP;
          w_dem_n[w_ap_n] = 1'b0;
        end
      end
      default: begin
        if (!bus.Flash) begin
          w_state_n = ST_ALLRED;
          w_timer_n = C_AR;
          w_rest_n  = 1'b1;
        end else if (r_fcnt <= C_ONE) begin
          w_fcnt_n = C_HALF;
          w_lit_n  = ~r_lit;
        end else begin
          w_fcnt_n = r_fcnt - C_ONE;
        end
      end
    endcase
  end

  always_comb begin
    w_lights_n = '1;
    for (int i = 0; i < NUM_PHASES; i++) begin
      case (w_state_n)
        ST_GREEN:
          if (w_ap_n == AW'(i)) w_lights_n[2*i +: 2] = L_GRN;
        ST_YELLOW:
          if (w_ap_n == AW'(i)) w_lights_n[2*i +: 2] = L_YEL;
        ST_FLASH:
          if (!w_lit_n)             w_lights_n[2*i +: 2] = L_DARK;
          else if (i == REST_PHASE) w_lights_n[2*i +: 2] = L_YEL;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state     <= ST_ALLRED;
      r_timer     <= C_AR;
      r_g         <= '0;
      r_gap       <= '0;
      r_fcnt      <= '0;
      r_lit       <= 1'b0;
      r_rest      <= 1'b1;
      r_dem       <= '0;
      r_ap        <= C_REST;
      r_lights    <= '1;
      r_flash_act <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_timer     <= w_timer_n;
      r_g         <= w_g_n;
      r_gap       <= w_gap_n;
      r_fcnt      <= w_fcnt_n;
      r_lit       <= w_lit_n;
      r_rest      <= w_rest_n;
      r_dem       <= w_dem_n;
      r_ap        <= w_ap_n;
      r_lights    <= w_lights_n;
      r_flash_act <= (w_state_n == ST_FLASH);
    end
  end

  assign bus.Lights      = r_lights;
  assign bus.ActivePhase = r_ap;
  assign bus.FlashActive = r_flash_act;
endmodule
